la_iocfg: RTL and testbench

LA_IOCFG -- requirements
Module: la_iocfg

---
 rtl/la_iocfg_pkg.sv | 8 +
 rtl/la_iocfg_div.sv | 18 +
 rtl/la_iocfg.sv | 115 +++++++++++
 tb/tb_la_iocfg.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/la_iocfg_pkg.sv
// la_iocfg_pkg: shared FSM state encoding and io ring bit positions for la_iocfg.
package la_iocfg_pkg;
  typedef enum logic [2:0] {S_IDLE, S_SLO, S_SHI, S_LATCH, S_DONE} state_t;
  localparam int SCLK = 0;
  localparam int SDATA = 1;
  localparam int LATCH = 2;
  localparam int SDO = 3;
endpackage

// File: rtl/la_iocfg_div.sv
// la_iocfg_div: half-period tick counter; reloads on i_load and ticks on the last cycle of a period.
module la_iocfg_div #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic nreset,
  input  logic i_load,
  output logic o_tick
);
  localparam int W = $clog2(DIV + 1);
  localparam logic [W-1:0] RELOAD = W'(DIV - 1);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) r_cnt <= '0;
    else if (i_load) r_cnt <= RELOAD;
    else if (r_cnt != '0) r_cnt <= r_cnt - W'(1);
  assign o_tick = r_cnt == '0;
endmodule

// File: rtl/la_iocfg.sv
// la_iocfg: serial io-ring configuration shifter (sclk/sdata/latch) with optional readback.
// Define LA_IOCFG_READBACK_EN to capture the ring return into rb_data and flag mismatches on err.
module la_iocfg
  import la_iocfg_pkg::*;
#(
  parameter string PROP  = "DEFAULT",
  parameter string SIDE  = "NO",
  parameter int    RINGW = 8,
  parameter int    NPADS = 8,
  parameter int    CFGW  = 4,
  parameter int    DIV   = 2
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [NPADS*CFGW-1:0]  cfg_data,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [NPADS*CFGW-1:0]  rb_data,
  inout  wire  [RINGW-1:0]       ioring
);
  localparam int N = NPADS * CFGW;
  localparam int CW = $clog2(N + 1);
  if (RINGW < 4 || DIV < 1) begin : g_bad
    $error("la_iocfg: RINGW must be >= 4 and DIV >= 1");
  end
  state_t r_state, w_nxt;
  logic [N-1:0] r_sr;
  logic [CW-1:0] r_cnt;
  logic r_sclk, r_latch, r_done;
  logic w_acc, w_tick, w_load, w_last, w_shift;
  assign cfg_ready = r_state == S_IDLE;
  assign busy = !cfg_ready;
  assign done = r_done;
  assign w_acc = cfg_valid && cfg_ready;
  assign w_last = r_cnt == CW'(1);
  assign w_shift = r_state == S_SHI && w_tick;
  assign w_load = w_nxt != r_state;
  la_iocfg_div #(.DIV(DIV)) u_div (
    .clk    (clk),
    .nreset (nreset),
    .i_load (w_load),
    .o_tick (w_tick)
  );
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_acc) w_nxt = S_SLO;
      S_SLO:   if (w_tick) w_nxt = S_SHI;
      S_SHI:   if (w_tick) w_nxt = w_last ? S_LATCH : S_SLO;
      S_LATCH: if (w_tick) w_nxt = S_DONE;
      default: w_nxt = S_IDLE;
    endcase
  end
  // Ring strobes are registered from the next state so they line up with r_state without decode glitches.
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      r_state <= S_IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_sclk  <= 1'b0;
      r_latch <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_sclk  <= w_nxt == S_SHI;
      r_latch <= w_nxt == S_LATCH;
      r_done  <= w_nxt == S_DONE;
      if (w_acc) begin
        r_sr  <= cfg_data;
        r_cnt <= CW'(N);
      end else if (w_shift) begin
        r_sr  <= r_sr << 1;
        r_cnt <= r_cnt - CW'(1);
      end
    end
  assign ioring[SCLK]  = r_sclk;
  assign ioring[SDATA] = r_sr[N-1];
  assign ioring[LATCH] = r_latch;
  if (RINGW > 4) begin : g_hiz
    assign ioring[RINGW-1:SDO+1] = {(RINGW-4){1'bz}};
  end
`ifdef LA_IOCFG_READBACK_EN
  logic [N-1:0] r_cap, r_cur, r_last, r_rb;
  logic r_vld, r_err;
  // The chain returns its old contents while the new word shifts in, so r_cap ends up as the previous image.
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      r_cap  <= '0;
      r_cur  <= '0;
      r_last <= '0;
      r_rb   <= '0;
      r_vld  <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      if (w_acc) r_cur <= cfg_data;
      if (r_state == S_SLO && w_nxt == S_SHI) r_cap <= {r_cap[N-2:0], ioring[SDO]};
      if (r_state == S_DONE) begin
        r_rb   <= r_cap;
        r_last <= r_cur;
        r_vld  <= 1'b1;
        if (r_vld && r_cap != r_last) r_err <= 1'b1;
      end
    end
  assign rb_data = r_rb;
  assign err = r_err;
`else
  logic w_unused_sdo;
  assign w_unused_sdo = ioring[SDO];
  assign rb_data = '0;
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_la_iocfg.sv
// tb_la_iocfg: directed self-checking bench for la_iocfg with an 8-bit ring shifting on sclk rise.
module tb_la_iocfg;
`ifdef LA_IOCFG_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  logic clk = 1'b0, nreset = 1'b0, cfg_valid = 1'b0;
  logic [7:0] cfg_data = '0;
  logic cfg_ready, busy, done, err;
  logic [7:0] rb_data;
  wire [7:0] ioring;
  logic [7:0] ring = '0, ring_set_val = '0, sd_bits = '0, exp_prev = '0;
  logic ring_set = 1'b0, p_sclk = 1'b0, p_latch = 1'b0;
  int checks = 0, failures = 0;
  int cyc = 0, rises = 0, lat_cyc = 0, lat_pulses = 0, done_cnt = 0, busy_cyc = 0;
  int acc_cnt = 0, acc_cyc = 0, acc_gap = 0, last_lat = 0, overlap = 0;

  assign ioring[3] = ring[7];
  always #5 clk = ~clk;

  la_iocfg #(.RINGW(8), .NPADS(2), .CFGW(4), .DIV(2)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_data  (cfg_data),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rb_data   (rb_data),
    .ioring    (ioring)
  );

  always @(negedge clk) begin
    cyc++;
    if (ring_set) ring = ring_set_val;
    else if (ioring[0] && !p_sclk) begin
      ring = {ring[6:0], ioring[1]};
      sd_bits = {sd_bits[6:0], ioring[1]};
      rises++;
    end
    if (ioring[2]) lat_cyc++;
    if (ioring[2] && !p_latch) lat_pulses++;
    if (done) begin
      done_cnt++;
      last_lat = cyc - acc_cyc;
    end
    if (busy) busy_cyc++;
    if (busy === cfg_ready) overlap++;
    if (cfg_valid && cfg_ready && nreset) begin
      acc_cnt++;
      acc_gap = cyc - acc_cyc;
      acc_cyc = cyc;
    end
    p_sclk = ioring[0];
    p_latch = ioring[2];
  end

  task automatic send(input logic [7:0] w);
    @(posedge clk); #1 cfg_data = w; cfg_valid = 1'b1;
    @(posedge clk); #1 cfg_valid = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    int d0 = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk); #1;
      ok = done_cnt != d0;
    end
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    nreset = 1'b0;
    repeat (3) @(negedge clk);
    checks += 6;
    if (cfg_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", cfg_ready); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
    if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", err); end
    if (rb_data !== 8'h00) begin failures++; $display("FAIL reset_rb: got %h want 00", rb_data); end
    if (ioring[2:0] !== 3'b000) begin failures++; $display("FAIL reset_ring: got %b want 000", ioring[2:0]); end
    @(posedge clk); #1 nreset = 1'b1;
  endtask

  task automatic test_basic;
    bit ok;
    int r0 = rises, l0 = lat_cyc, p0 = lat_pulses, d0 = done_cnt, b0 = busy_cyc;
    send(8'hA5);
    wait_done(ok);
    checks += 10;
    if (!ok) begin failures++; $display("FAIL basic_timeout: got no done want done"); end
    if (sd_bits !== 8'hA5) begin failures++; $display("FAIL basic_sdata: got %h want a5", sd_bits); end
    if (rises - r0 != 8) begin failures++; $display("FAIL basic_rises: got %0d want 8", rises - r0); end
    if (lat_cyc - l0 != 2) begin failures++; $display("FAIL basic_latch_len: got %0d want 2", lat_cyc - l0); end
    if (lat_pulses - p0 != 1) begin failures++; $display("FAIL basic_latch_pulses: got %0d want 1", lat_pulses - p0); end
    if (last_lat != 35) begin failures++; $display("FAIL basic_latency: got %0d want 35", last_lat); end
    if (done_cnt - d0 != 1) begin failures++; $display("FAIL basic_done_width: got %0d want 1", done_cnt - d0); end
    if (busy_cyc - b0 != 35) begin failures++; $display("FAIL basic_busy_len: got %0d want 35", busy_cyc - b0); end
    if (rb_data !== (RB ? exp_prev : 8'h00)) begin failures++; $display("FAIL basic_rb: got %h want %h", rb_data, RB ? exp_prev : 8'h00); end
    if (err !== 1'b0) begin failures++; $display("FAIL basic_err: got %b want 0", err); end
    exp_prev = 8'hA5;
  endtask

  task automatic test_readback;
    bit ok;
    send(8'h3C);
    wait_done(ok);
    checks += 4;
    if (!ok) begin failures++; $display("FAIL rb_timeout: got no done want done"); end
    if (sd_bits !== 8'h3C) begin failures++; $display("FAIL rb_sdata: got %h want 3c", sd_bits); end
    if (rb_data !== (RB ? 8'hA5 : 8'h00)) begin failures++; $display("FAIL rb_data: got %h want %h", rb_data, RB ? 8'hA5 : 8'h00); end
    if (err !== 1'b0) begin failures++; $display("FAIL rb_err: got %b want 0", err); end
    exp_prev = 8'h3C;
  endtask

  task automatic test_err;
    bit ok;
    ring_set_val = 8'hFF; ring_set = 1'b1;
    @(negedge clk); #1 ring_set = 1'b0;
    send(8'h0F);
    wait_done(ok);
    checks += 3;
    if (!ok) begin failures++; $display("FAIL err_timeout: got no done want done"); end
    if (rb_data !== (RB ? 8'hFF : 8'h00)) begin failures++; $display("FAIL err_rb: got %h want %h", rb_data, RB ? 8'hFF : 8'h00); end
    if (err !== RB) begin failures++; $display("FAIL err_set: got %b want %b", err, RB); end
    send(8'h0F);
    wait_done(ok);
    checks += 3;
    if (!ok) begin failures++; $display("FAIL err2_timeout: got no done want done"); end
    if (rb_data !== (RB ? 8'h0F : 8'h00)) begin failures++; $display("FAIL err2_rb: got %h want %h", rb_data, RB ? 8'h0F : 8'h00); end
    if (err !== RB) begin failures++; $display("FAIL err_sticky: got %b want %b", err, RB); end
    exp_prev = 8'h0F;
  endtask

  task automatic test_back_to_back;
    bit ok, got2;
    int a0 = acc_cnt, o0 = overlap;
    @(posedge clk); #1 cfg_data = 8'h96; cfg_valid = 1'b1;
    got2 = 1'b0;
    for (int i = 0; i < 200 && !got2; i++) begin
      @(negedge clk); #1;
      got2 = acc_cnt - a0 >= 2;
    end
    @(posedge clk); #1 cfg_valid = 1'b0;
    wait_done(ok);
    checks += 6;
    if (!got2) begin failures++; $display("FAIL b2b_accepts_timeout: got %0d want 2", acc_cnt - a0); end
    if (!ok) begin failures++; $display("FAIL b2b_timeout: got no done want done"); end
    if (acc_gap != 36) begin failures++; $display("FAIL b2b_gap: got %0d want 36", acc_gap); end
    if (acc_cnt - a0 != 2) begin failures++; $display("FAIL b2b_count: got %0d want 2", acc_cnt - a0); end
    if (overlap != o0) begin failures++; $display("FAIL b2b_ready_busy: got %0d bad cycles want 0", overlap - o0); end
    if (rb_data !== (RB ? 8'h96 : 8'h00)) begin failures++; $display("FAIL b2b_rb: got %h want %h", rb_data, RB ? 8'h96 : 8'h00); end
    exp_prev = 8'h96;
  endtask

  task automatic test_reset_abort;
    bit ok, hit;
    int r0 = rises, p0 = lat_pulses;
    logic [7:0] w = 8'hC3;
    send(w);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk); #1;
      hit = rises - r0 >= 5;
    end
    #1 nreset = 1'b0;
    #1;
    checks += 4;
    if (!hit) begin failures++; $display("FAIL abort_reach_bit4: got %0d rises want 5", rises - r0); end
    if (ioring[2:0] !== 3'b000) begin failures++; $display("FAIL abort_ring: got %b want 000", ioring[2:0]); end
    if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b want 0", busy); end
    if (cfg_ready !== 1'b1) begin failures++; $display("FAIL abort_ready: got %b want 1", cfg_ready); end
    repeat (3) @(negedge clk);
    #1;
    checks += 3;
    if (lat_pulses != p0) begin failures++; $display("FAIL abort_latch: got %0d pulses want 0", lat_pulses - p0); end
    if (err !== 1'b0) begin failures++; $display("FAIL abort_err: got %b want 0", err); end
    if (rb_data !== 8'h00) begin failures++; $display("FAIL abort_rb: got %h want 00", rb_data); end
    exp_prev = {exp_prev[2:0], w[7:3]};
    @(posedge clk); #1 nreset = 1'b1;
    p0 = lat_pulses;
    send(8'h5A);
    wait_done(ok);
    checks += 6;
    if (!ok) begin failures++; $display("FAIL post_timeout: got no done want done"); end
    if (sd_bits !== 8'h5A) begin failures++; $display("FAIL post_sdata: got %h want 5a", sd_bits); end
    if (last_lat != 35) begin failures++; $display("FAIL post_latency: got %0d want 35", last_lat); end
    if (lat_pulses - p0 != 1) begin failures++; $display("FAIL post_latch: got %0d want 1", lat_pulses - p0); end
    if (rb_data !== (RB ? exp_prev : 8'h00)) begin failures++; $display("FAIL post_rb: got %h want %h", rb_data, RB ? exp_prev : 8'h00); end
    if (err !== 1'b0) begin failures++; $display("FAIL post_err: got %b want 0", err); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_readback;
    test_err;
    test_back_to_back;
    test_reset_abort;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
